// File: rtl/gauss_blur_3x3_pkg.sv
// Shared types, constants and kernel arithmetic for the 3x3 Gaussian blur.
// The blur function is applied once per colour channel by the top level.
package gauss_blur_3x3_pkg;

    localparam int PIX_W       = 4;
    localparam int RGB_W       = 3 * PIX_W;
    localparam int SUM_W       = 8;
    localparam int NORM_SHIFT  = 4;
    localparam int ROUND_CONST = 8;

    // [row][col] weights of the [1 2 1; 2 4 2; 1 2 1] kernel.
    localparam logic [2:0][2:0][2:0] KERNEL = '{
        '{3'd1, 3'd2, 3'd1},
        '{3'd2, 3'd4, 3'd2},
        '{3'd1, 3'd2, 3'd1}
    };

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // One channel's 3x3 neighbourhood, indexed [row][col].
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    function automatic int coord_width(input int w, input int h);
        int m;
        m = (w > h) ? w : h;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Weighted sum peaks at 16*15 = 240, so rounding still fits in 8 bits.
    function automatic logic [PIX_W-1:0] blur_channel(input win_t win);
        logic [SUM_W-1:0] sum;
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + SUM_W'(KERNEL[r][c]) * SUM_W'(win[r][c]);
            end
        end
        sum = sum + SUM_W'(ROUND_CONST);
        return PIX_W'(sum >> NORM_SHIFT);
    endfunction

endpackage

// File: rtl/gauss_blur_3x3_line_buffer.sv
// One row of packed RGB pixels: asynchronous read and synchronous write at the
// same column, so a beat sees the previous row's value before overwriting it.
module gauss_blur_3x3_line_buffer #(
    parameter int Depth = 400,
    parameter int DataW = 12,
    parameter int AddrW = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] addr,
    input  logic [DataW-1:0] wr_data,
    output logic [DataW-1:0] rd_data
);

    logic [DataW-1:0] mem [Depth];

    assign rd_data = mem[addr];

    // NOTE: storage arrays get no reset; every entry is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/gauss_blur_3x3.sv
// Streaming 3x3 Gaussian blur over 4-bit RGB pixels in raster order; emits one
// registered result per interior pixel, one cycle after the beat completing it.
module gauss_blur_3x3
    import gauss_blur_3x3_pkg::*;
#(
    parameter int Width  = 400,
    parameter int Height = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_R,
    input  logic [PIX_W-1:0] pix_G,
    input  logic [PIX_W-1:0] pix_B,
    input  logic             frame_restart,
    output logic             out_valid,
    output logic [PIX_W-1:0] blur_R,
    output logic [PIX_W-1:0] blur_G,
    output logic [PIX_W-1:0] blur_B,
    output logic             frame_done
);

    localparam int CW = coord_width(Width, Height);

    logic [CW-1:0] x, y;
    logic [CW-1:0] cur_x, cur_y;
    logic [CW-1:0] next_x, next_y;
    logic          fire, last_pix;

    rgb_t pix, row1, row2;
    rgb_t col_new [3];
    rgb_t win_q   [3][2];
    win_t win_r, win_g, win_b;

    // A restart beat is pixel (0,0) of a new frame.
    assign cur_x = frame_restart ? '0 : x;
    assign cur_y = frame_restart ? '0 : y;

    assign pix = {pix_R, pix_G, pix_B};

    // row1 holds row y-1 at this column, row2 holds row y-2.
    gauss_blur_3x3_line_buffer #(.Depth(Width), .DataW(RGB_W), .AddrW(CW)) u_line_buffer_1 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_x),
        .wr_data (pix),
        .rd_data (row1)
    );

    gauss_blur_3x3_line_buffer #(.Depth(Width), .DataW(RGB_W), .AddrW(CW)) u_line_buffer_2 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_x),
        .wr_data (row1),
        .rd_data (row2)
    );

    assign col_new[0] = row2;
    assign col_new[1] = row1;
    assign col_new[2] = pix;

    assign fire     = pix_valid && (cur_x >= CW'(2)) && (cur_y >= CW'(2));
    assign last_pix = (cur_x == CW'(Width - 1)) && (cur_y == CW'(Height - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_x = cur_x;
        next_y = cur_y;
        if (pix_valid) begin
            if (cur_x == CW'(Width - 1)) begin
                next_x = '0;
                next_y = (cur_y == CW'(Height - 1)) ? '0 : cur_y + CW'(1);
            end else begin
                next_x = cur_x + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= next_x;
            y <= next_y;
        end
    end

    // Columns 0 and 1 of the window hold columns x-2 and x-1.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= col_new[r];
            end
        end
    end

    always_comb begin
        win_r = '0;
        win_g = '0;
        win_b = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_r[r][c] = win_q[r][c].r;
                win_g[r][c] = win_q[r][c].g;
                win_b[r][c] = win_q[r][c].b;
            end
            win_r[r][2] = col_new[r].r;
            win_g[r][2] = col_new[r].g;
            win_b[r][2] = col_new[r].b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            blur_R     <= '0;
            blur_G     <= '0;
            blur_B     <= '0;
        end else begin
            out_valid  <= fire;
            frame_done <= fire && last_pix;
            blur_R     <= fire ? blur_channel(win_r) : '0;
            blur_G     <= fire ? blur_channel(win_g) : '0;
            blur_B     <= fire ? blur_channel(win_b) : '0;
        end
    end

endmodule
